// File: rtl/wave_synth_core_if.sv
// Control/sample bus between the wave selector side and wave_synth_core.
// The amp field exists only when WAVE_AMP_SCALE_EN is defined.
interface wave_synth_core_if #(
    parameter int PHASE_W = 24,
    parameter int OUT_W   = 16
);
    logic               sample_en;
    logic [2:0]         wave_sel;
    logic [PHASE_W-1:0] tuning_word;
`ifdef WAVE_AMP_SCALE_EN
    logic [3:0]         amp;
`endif
    logic [OUT_W-1:0]   sample_out;
    logic               sample_valid;
    logic [2:0]         active_sel;

`ifdef WAVE_AMP_SCALE_EN
    modport master (output sample_en, wave_sel, tuning_word, amp,
                    input  sample_out, sample_valid, active_sel);
    modport slave  (input  sample_en, wave_sel, tuning_word, amp,
                    output sample_out, sample_valid, active_sel);
`else
    modport master (output sample_en, wave_sel, tuning_word,
                    input  sample_out, sample_valid, active_sel);
    modport slave  (input  sample_en, wave_sel, tuning_word,
                    output sample_out, sample_valid, active_sel);
`endif
endinterface

// File: rtl/wave_synth_core.sv
// Phase-accumulator waveform generator; wave changes land only on a phase wrap.
// Optional macro WAVE_AMP_SCALE_EN adds a 4-bit amplitude scaler on bus.amp.
module wave_synth_core #(
    parameter int          PHASE_W   = 24,
    parameter int          OUT_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic              clk,
    input logic              reset,
    wave_synth_core_if.slave bus
);
    logic [PHASE_W-1:0] phase, nphase;
    logic               wrap;
    logic [2:0]         pending_sel, active_q, sel;
    logic [15:0]        lfsr, lfsr_nxt;
    logic [OUT_W-1:0]   p, raw, shaped, sq_v, saw_v, tri_v, noise_v, out_q;
    logic [OUT_W-2:0]   fold;
    logic               valid_q;

    assign {wrap, nphase} = {1'b0, phase} + {1'b0, bus.tuning_word};
    assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    // A frozen phase never wraps, so a zero tuning word lets the selection through directly.
    assign sel = (wrap || (bus.tuning_word == '0)) ? pending_sel : active_q;

    assign p     = nphase[PHASE_W-1 -: OUT_W];
    assign sq_v  = p[OUT_W-1] ? {1'b1, {(OUT_W-2){1'b0}}, 1'b1} : {1'b0, {(OUT_W-1){1'b1}}};
    assign saw_v = {~p[OUT_W-1], p[OUT_W-2:0]};
    assign fold  = p[OUT_W-1] ? ~p[OUT_W-2:0] : p[OUT_W-2:0];
    assign tri_v = {~fold[OUT_W-2], fold[OUT_W-3:0], 1'b0};

    generate
        if (OUT_W >= 16) begin : g_noise_ext
            if (OUT_W > 16) begin : g_pad
                assign noise_v = {{(OUT_W-16){1'b0}}, lfsr_nxt};
            end else begin : g_same
                assign noise_v = lfsr_nxt;
            end
        end else begin : g_noise_trunc
            assign noise_v = lfsr_nxt[OUT_W-1:0];
        end
    endgenerate

    always_comb begin
        raw = '0;
        case (sel)
            3'b000:  raw = sq_v;
            3'b001:  raw = saw_v;
            3'b010:  raw = tri_v;
            3'b011:  raw = ~saw_v;
            3'b100:  raw = noise_v;
            default: raw = '0;
        endcase
    end

`ifdef WAVE_AMP_SCALE_EN
    // Product of a signed sample and (amp+1) <= 16 fits in OUT_W+4 signed bits.
    logic [4:0]                amp_p1;
    logic signed [OUT_W+3:0]   raw_x, amp_x, prod;
    assign amp_p1 = {1'b0, bus.amp} + 5'd1;
    assign raw_x  = {{4{raw[OUT_W-1]}}, raw};
    assign amp_x  = {{(OUT_W-1){1'b0}}, amp_p1};
    assign prod   = raw_x * amp_x;
    assign shaped = OUT_W'(prod >>> 4);
`else
    assign shaped = raw;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase       <= '0;
            active_q    <= '0;
            pending_sel <= '0;
            lfsr        <= LFSR_SEED;
            out_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            pending_sel <= bus.wave_sel;
            valid_q     <= bus.sample_en;
            if (bus.sample_en) begin
                phase    <= nphase;
                lfsr     <= lfsr_nxt;
                active_q <= sel;
                out_q    <= shaped;
            end
        end
    end

    assign bus.sample_out   = out_q;
    assign bus.sample_valid = valid_q;
    assign bus.active_sel   = active_q;
endmodule

// File: tb/tb_wave_synth_core.sv
// Directed bench for wave_synth_core: table of strobes plus hand sequences.
module tb_wave_synth_core;
    localparam int PHASE_W = 24;
    localparam int OUT_W   = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wave_synth_core_if #(.PHASE_W(PHASE_W), .OUT_W(OUT_W)) bus ();
    wave_synth_core #(.PHASE_W(PHASE_W), .OUT_W(OUT_W), .LFSR_SEED(16'hACE1))
        dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] exp_out;
        logic [2:0]  exp_act;
    } vec_t;

    vec_t        vecs [56];
    logic [15:0] tri_tab [16];
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Select is presented one idle cycle ahead so pending_sel holds it at the strobe edge.
    task automatic strobe(input logic [2:0] s);
        bus.wave_sel = s;
        @(negedge clk);
        bus.sample_en = 1'b1;
        @(negedge clk);
        bus.sample_en = 1'b0;
    endtask

    task automatic chk_out(input string name, input logic [15:0] e_out, input logic [2:0] e_act);
        chk({name, " valid"}, 16'(bus.sample_valid), 16'd1);
        chk({name, " out"}, bus.sample_out, e_out);
        chk({name, " act"}, 16'(bus.active_sel), 16'(e_act));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset           = 1'b1;
        bus.sample_en   = 1'b0;
        bus.wave_sel    = 3'd0;
        bus.tuning_word = 24'h100000;
`ifdef WAVE_AMP_SCALE_EN
        bus.amp         = 4'd15;
`endif
        tri_tab = '{16'h8000, 16'hA000, 16'hC000, 16'hE000, 16'h0000, 16'h2000, 16'h4000, 16'h6000,
                    16'h7FFE, 16'h5FFE, 16'h3FFE, 16'h1FFE, 16'hFFFE, 16'hDFFE, 16'hBFFE, 16'h9FFE};

        // Period A: square. Period B: switch to triangle at k=5, lands at wrap.
        // Period C: several select changes, only the one at the wrap (1) applies. D: sawtooth.
        for (int i = 0; i < 56; i++) begin
            int k;
            if (i < 16) begin
                k = i + 1;
                vecs[i] = '{3'd0, (k < 8 || k == 16) ? 16'h7FFF : 16'h8001, 3'd0};
            end else if (i < 32) begin
                k = i - 15;
                vecs[i].sel = (k < 5) ? 3'd0 : 3'd2;
                if (k == 16) begin
                    vecs[i].exp_out = 16'h8000;
                    vecs[i].exp_act = 3'd2;
                end else begin
                    vecs[i].exp_out = (k < 8) ? 16'h7FFF : 16'h8001;
                    vecs[i].exp_act = 3'd0;
                end
            end else if (i < 48) begin
                k = i - 31;
                vecs[i].sel = (k <= 3) ? 3'd2 : (k <= 8) ? 3'd3 : (k <= 12) ? 3'd5 : 3'd1;
                vecs[i].exp_out = (k < 16) ? tri_tab[k] : 16'h8000;
                vecs[i].exp_act = (k < 16) ? 3'd2 : 3'd1;
            end else begin
                k = i - 47;
                vecs[i] = '{3'd1, 16'(k * 16'h1000) ^ 16'h8000, 3'd1};
            end
        end

        #12;
        chk("reset out", bus.sample_out, 16'h0000);
        chk("reset valid", 16'(bus.sample_valid), 16'd0);
        chk("reset act", 16'(bus.active_sel), 16'd0);

        do_reset();
        for (int i = 0; i < 56; i++) begin
            strobe(vecs[i].sel);
            chk_out($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_act);
            if (i % 8 == 0) begin
                @(negedge clk);
                chk($sformatf("vec%0d valid drop", i), 16'(bus.sample_valid), 16'd0);
            end
        end

        // Select requested during reset stays square until the first wrap.
        bus.wave_sel = 3'd1;
        do_reset();
        strobe(3'd1);
        chk_out("pre-wrap s1", 16'h7FFF, 3'd0);
        for (int i = 2; i < 16; i++) strobe(3'd1);
        strobe(3'd1);
        chk_out("wrap s16 saw", 16'h8000, 3'd1);
        strobe(3'd1);
        chk_out("saw s17", 16'h9000, 3'd1);

        // Select changing on the wrapping strobe's own cycle misses that wrap.
        bus.wave_sel = 3'd0;
        do_reset();
        for (int i = 1; i < 16; i++) strobe(3'd0);
        @(negedge clk);
        bus.wave_sel  = 3'd1;
        bus.sample_en = 1'b1;
        @(negedge clk);
        bus.sample_en = 1'b0;
        chk_out("same-cycle wrap", 16'h7FFF, 3'd0);
        strobe(3'd1);
        chk_out("after same-cycle", 16'h7FFF, 3'd0);

        // Zero tuning word: selection applies at once; noise follows the LFSR.
        bus.wave_sel    = 3'd0;
        do_reset();
        bus.tuning_word = 24'h0;
        strobe(3'd4);
        chk_out("noise1", 16'h59C3, 3'd4);
        strobe(3'd4);
        chk_out("noise2", 16'hB387, 3'd4);
        strobe(3'd4);
        chk_out("noise3", 16'h670F, 3'd4);
        strobe(3'd4);
        chk_out("noise4", 16'hCE1E, 3'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold valid", 16'(bus.sample_valid), 16'd0);
            chk("hold out", bus.sample_out, 16'hCE1E);
        end
        strobe(3'd0);
        chk_out("tw0 back to square", 16'h7FFF, 3'd0);

        // Silence code, then asynchronous reset mid-period.
        bus.tuning_word = 24'h100000;
        do_reset();
        strobe(3'd6);
        chk_out("sil s1", 16'h7FFF, 3'd0);
        for (int i = 2; i < 16; i++) strobe(3'd6);
        strobe(3'd6);
        chk_out("sil wrap", 16'h0000, 3'd6);
        for (int i = 0; i < 3; i++) strobe(3'd6);
        #2 reset = 1'b1;
        #1;
        chk("async out", bus.sample_out, 16'h0000);
        chk("async valid", 16'(bus.sample_valid), 16'd0);
        chk("async act", 16'(bus.active_sel), 16'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 1; i < 8; i++) strobe(3'd0);
        chk_out("post-reset s7", 16'h7FFF, 3'd0);
        strobe(3'd0);
        chk_out("post-reset s8", 16'h8001, 3'd0);

`ifdef WAVE_AMP_SCALE_EN
        do_reset();
        bus.amp = 4'd7;
        strobe(3'd0);
        chk_out("amp7 hi", 16'h3FFF, 3'd0);
        for (int i = 2; i < 8; i++) strobe(3'd0);
        strobe(3'd0);
        chk_out("amp7 lo", 16'hC000, 3'd0);
        bus.amp = 4'd15;
        strobe(3'd0);
        chk_out("amp15 lo", 16'h8001, 3'd0);
        bus.amp = 4'd0;
        strobe(3'd0);
        chk_out("amp0 lo", 16'hF800, 3'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
